// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
// Optional build macro: RF_ARB_X0_ZERO_EN (force index-0 reads to zero).
package rf_arb_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 32;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

    localparam req_id_t REQ_RS1   = req_id_t'(0);
    localparam req_id_t REQ_RS2   = req_id_t'(1);
    localparam req_id_t REQ_DBG   = req_id_t'(2);
    localparam req_id_t REQ_SPARE = req_id_t'(3);

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// Round-robin one-hot picker with an internal priority pointer.
// The pick is purely combinational; only the pointer is registered.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    logic [ID_W-1:0] ptr;

    // No grants while in reset so nothing is handed out before the pipeline is live.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        if (rst_n && !stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_id   = ID_W'(idx);
                    grant_any  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file read mux among NUM_REQ requesters, 2-cycle fixed latency.
// Optional build macro: RF_ARB_X0_ZERO_EN (index-0 reads return zero).
module regfile_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_IDX_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [REG_IDX_W-1:0]         mux_select,
    input  logic [WIDTH-1:0]             mux_data,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [WIDTH-1:0]             rsp_data
);

    logic [ID_W-1:0]      grant_id;
    logic                 grant_any;
    logic [REG_IDX_W-1:0] sel_addr;
    logic                 s1_valid;
    logic [ID_W-1:0]      s1_id;
    logic [WIDTH-1:0]     read_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .req_valid (req_valid),
        .grant     (req_ready),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign sel_addr = req_addr[int'(grant_id)*REG_IDX_W +: REG_IDX_W];

`ifdef RF_ARB_X0_ZERO_EN
    // mux_select still carries the S1 index while its data is being sampled.
    assign read_data = (mux_select == '0) ? '0 : mux_data;
`else
    assign read_data = mux_data;
`endif

    // S0: latch the winner's index onto the mux select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_select <= '0;
            s1_valid   <= 1'b0;
            s1_id      <= '0;
        end else begin
            s1_valid <= grant_any;
            if (grant_any) begin
                mux_select <= sel_addr;
                s1_id      <= grant_id;
            end
        end
    end

    // S1: capture mux output and strobe the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= s1_valid ? (NUM_REQ'(1) << s1_id) : '0;
            if (s1_valid) begin
                rsp_id   <= s1_id;
                rsp_data <= read_data;
            end
        end
    end

endmodule
